// File: rtl/rx_qpsk.sv
// QPSK phase de-rotator: multiplies each of N_LANES complex samples by j^phase.
// One registered stage; negation saturates so the most negative code maps to +max.
module rx_qpsk #(
   parameter int N_LANES  = 4,
   parameter int SAMPLE_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_LANES*SAMPLE_W-1:0]   I_in,
   input  logic [N_LANES*SAMPLE_W-1:0]   Q_in,
   input  logic [1:0]                    phase,
   output logic [N_LANES*SAMPLE_W-1:0]   I_out,
   output logic [N_LANES*SAMPLE_W-1:0]   Q_out
);

   localparam int WORD_W = N_LANES * SAMPLE_W;

   logic [WORD_W-1:0] i_nxt;
   logic [WORD_W-1:0] q_nxt;

   function automatic logic [SAMPLE_W-1:0] neg_sat(
      input logic [SAMPLE_W-1:0] x
   );
      logic [SAMPLE_W-1:0] min_v;
      min_v = {1'b1, {(SAMPLE_W-1){1'b0}}};
      if (x == min_v)
         return ~min_v;
      else
         return -x;
   endfunction

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      logic [SAMPLE_W-1:0] i_l;
      logic [SAMPLE_W-1:0] q_l;
      logic [SAMPLE_W-1:0] i_r;
      logic [SAMPLE_W-1:0] q_r;

      assign i_l = I_in[k*SAMPLE_W +: SAMPLE_W];
      assign q_l = Q_in[k*SAMPLE_W +: SAMPLE_W];

      always_comb begin
         i_r = i_l;
         q_r = q_l;
         unique case (phase)
            2'd0: begin
               i_r = i_l;
               q_r = q_l;
            end
            2'd1: begin
               i_r = neg_sat(q_l);
               q_r = i_l;
            end
            2'd2: begin
               i_r = neg_sat(i_l);
               q_r = neg_sat(q_l);
            end
            2'd3: begin
               i_r = q_l;
               q_r = neg_sat(i_l);
            end
         endcase
      end

      assign i_nxt[k*SAMPLE_W +: SAMPLE_W] = i_r;
      assign q_nxt[k*SAMPLE_W +: SAMPLE_W] = q_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         I_out <= '0;
         Q_out <= '0;
      end else begin
         I_out <= i_nxt;
         Q_out <= q_nxt;
      end
   end

endmodule

// File: tb/tb_rx_qpsk.sv
// Bench for rx_qpsk: directed vector table, sine stream with phase cycling,
// and random words against a complex-arithmetic reference model.
module tb_rx_qpsk;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] I_in;
   logic [63:0] Q_in;
   logic [1:0]  phase;
   logic [63:0] I_out;
   logic [63:0] Q_out;

   int checks = 0;
   int failures = 0;

   rx_qpsk #(.N_LANES(4), .SAMPLE_W(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .I_in  (I_in),
      .Q_in  (Q_in),
      .phase (phase),
      .I_out (I_out),
      .Q_out (Q_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic [1:0]  phase;
      logic [63:0] i;
      logic [63:0] q;
      logic [63:0] exp_i;
      logic [63:0] exp_q;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [63:0] rep4(input logic [15:0] v);
      return {v, v, v, v};
   endfunction

   // Rotation as a complex product (i + jq)(c + js), result clamped to 16 bits.
   function automatic void model(
      input  logic [63:0] iw,
      input  logic [63:0] qw,
      input  logic [1:0]  p,
      output logic [63:0] io,
      output logic [63:0] qo
   );
      int c, s, iv, qv, a, b;
      c = 0;
      s = 0;
      case (p)
         2'd0: c = 1;
         2'd1: s = 1;
         2'd2: c = -1;
         default: s = -1;
      endcase
      io = '0;
      qo = '0;
      for (int k = 0; k < 4; k++) begin
         iv = int'($signed(iw[k*16 +: 16]));
         qv = int'($signed(qw[k*16 +: 16]));
         a = iv * c - qv * s;
         b = iv * s + qv * c;
         if (a > 32767) a = 32767;
         if (a < -32768) a = -32768;
         if (b > 32767) b = 32767;
         if (b < -32768) b = -32768;
         io[k*16 +: 16] = 16'(a);
         qo[k*16 +: 16] = 16'(b);
      end
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic [1:0] p,
                        input logic [63:0] iw, input logic [63:0] qw);
      rst   = r;
      phase = p;
      I_in  = iw;
      Q_in  = qw;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] ei, eq, iw, qw;
      logic [1:0]  pseq[4];
      logic        r;
      logic [1:0]  p;
      int          n, vi, vq;

      pseq[0] = 2'd0;
      pseq[1] = 2'd1;
      pseq[2] = 2'd3;
      pseq[3] = 2'd2;

      vecs[0] = '{"reset", 1'b1, 2'd0, rep4(16'h7FFF), rep4(16'h7FFF), 64'h0, 64'h0};
      vecs[1] = '{"post_reset", 1'b0, 2'd0, rep4(16'h7FFF), rep4(16'h7FFF),
                  rep4(16'h7FFF), rep4(16'h7FFF)};
      vecs[2] = '{"ph0_pass", 1'b0, 2'd0,
                  64'h0004_0003_0002_0001, 64'hFFFC_FFFD_FFFE_FFFF,
                  64'h0004_0003_0002_0001, 64'hFFFC_FFFD_FFFE_FFFF};
      vecs[3] = '{"ph1", 1'b0, 2'd1, rep4(16'd100), rep4(16'hFF38),
                  rep4(16'd200), rep4(16'd100)};
      vecs[4] = '{"ph2", 1'b0, 2'd2, rep4(16'd100), rep4(16'hFF38),
                  rep4(16'hFF9C), rep4(16'd200)};
      vecs[5] = '{"ph3", 1'b0, 2'd3, rep4(16'd100), rep4(16'hFF38),
                  rep4(16'hFF38), rep4(16'hFF9C)};
      vecs[6] = '{"sat_ph2", 1'b0, 2'd2,
                  64'h0064_0064_0064_8000, 64'hFF38_FF38_FF38_7FFF,
                  64'hFF9C_FF9C_FF9C_7FFF, 64'h00C8_00C8_00C8_8001};
      vecs[7] = '{"lanes_ph3", 1'b0, 2'd3,
                  64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A,
                  64'h0028_001E_0014_000A, 64'hFFFC_FFFD_FFFE_FFFF};
      vecs[8] = '{"reset_mid", 1'b1, 2'd1, rep4(16'd100), rep4(16'hFF38), 64'h0, 64'h0};
      vecs[9] = '{"sat_ph1", 1'b0, 2'd1, rep4(16'h1234), rep4(16'h8000),
                  rep4(16'h7FFF), rep4(16'h1234)};

      rst   = 1'b1;
      phase = 2'd0;
      I_in  = '0;
      Q_in  = '0;
      @(negedge clk);

      foreach (vecs[v]) begin
         apply(vecs[v].rst, vecs[v].phase, vecs[v].i, vecs[v].q);
         check({vecs[v].name, "_I"}, I_out, vecs[v].exp_i);
         check({vecs[v].name, "_Q"}, Q_out, vecs[v].exp_q);
      end

      // 10 MHz tone at an assumed 100 MS/s, lane 0 earliest in each word.
      for (int w = 0; w < 200; w++) begin
         p = pseq[w % 4];
         for (int k = 0; k < 4; k++) begin
            n  = w * 4 + k;
            vi = $rtoi(32767.0 * $cos(6.283185307179586 * 0.1 * n));
            vq = $rtoi(32767.0 * $sin(6.283185307179586 * 0.1 * n));
            iw[k*16 +: 16] = 16'(vi);
            qw[k*16 +: 16] = 16'(vq);
         end
         model(iw, qw, p, ei, eq);
         apply(1'b0, p, iw, qw);
         check("sine_I", I_out, ei);
         check("sine_Q", Q_out, eq);
      end

      // Random words with corner codes mixed in and occasional reset.
      for (int t = 0; t < 400; t++) begin
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 7))
               0: iw[k*16 +: 16] = 16'h8000;
               1: iw[k*16 +: 16] = 16'h7FFF;
               2: iw[k*16 +: 16] = 16'h0000;
               default: iw[k*16 +: 16] = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
               0: qw[k*16 +: 16] = 16'h8000;
               1: qw[k*16 +: 16] = 16'hFFFF;
               default: qw[k*16 +: 16] = 16'($urandom);
            endcase
         end
         p = 2'($urandom_range(0, 3));
         r = ($urandom_range(0, 15) == 0);
         model(iw, qw, p, ei, eq);
         if (r) begin
            ei = '0;
            eq = '0;
         end
         apply(r, p, iw, qw);
         check("rand_I", I_out, ei);
         check("rand_Q", Q_out, eq);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_qpsk.md
Name: rx_qpsk

Overview:
- Receiver-side QPSK phase de-rotator in the NMR spectrometer receive chain, placed between the quadrature demodulator and the downstream accumulation/decimation logic.
- Each clock it takes four parallel complex samples on I/Q buses and multiplies each by 1, j, -1 or -j, selected by a 2-bit phase code.
- Result is one registered stage.
- Enables phase cycling by undoing the transmit-pulse phase on received data.

Parameters:
- N_LANES, 4, number of parallel samples per bus word.
- SAMPLE_W, 16, width of each signed two's-complement sample.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- I_in  input  N_LANES*SAMPLE_W (64)  in-phase samples; lane k = bits [16k+15:16k]; lane 0 is the earliest sample.
- Q_in  input  N_LANES*SAMPLE_W (64)  quadrature samples, same lane packing as I_in.
- phase  input  2  rotation code: 0 = 0°, 1 = 90°, 2 = 180°, 3 = 270°.
- I_out  output  64  rotated in-phase samples, same lane packing.
- Q_out  output  64  rotated quadrature samples, same lane packing.

Behaviour:
- Reset: while rst=1 at a rising edge, I_out and Q_out are set to 0. rst has priority over all data.
- Latency: exactly 1 clock.
  - I_in, Q_in and phase sampled at edge n appear on I_out/Q_out after edge n.
  - No internal buffering beyond that one register.
  - Throughput is one 4-lane word per clock.
- Phase is sampled together with the data. A phase change takes effect on the word presented in the same cycle; there is no glitch or mixing between lanes.
- Per-lane mapping (identical for all lanes, lanes independent), with i = I lane and q = Q lane:
  - phase 0: I_out = i, Q_out = q (pass-through).
  - phase 1: I_out = -q, Q_out = i.
  - phase 2: I_out = -i, Q_out = -q.
  - phase 3: I_out = q, Q_out = -i.
- Negation is saturating two's complement: -(-32768) = +32767. All other values negate exactly; -0 = 0.
- No rounding and no width growth; outputs are SAMPLE_W per lane.
- No dependence on previous words; phase may change every cycle.
- Reset asserted mid-stream: the output is 0 on the next edge. The first word after rst deasserts is processed normally with 1-cycle latency.
- Outputs are driven only from registers; no combinational input-to-output path.

Test Plan:
- Reset: drive rst=1 with I_in=Q_in=64'h7FFF_7FFF_7FFF_7FFF, one edge -> I_out=Q_out=0. Deassert rst -> next edge outputs the phase-0 pass-through value.
- Phase 0 pass-through: I_in={4'sd?}=16'h0001,16'h0002,16'h0003,16'h0004 (lanes 0..3), Q_in=16'hFFFF,16'hFFFE,16'hFFFD,16'hFFFC -> after 1 clock I_out==I_in, Q_out==Q_in.
- Phase 1/2/3, all lanes with i=100, q=-200:
  - phase 1 -> I_out=200, Q_out=100.
  - phase 2 -> I_out=-100, Q_out=200.
  - phase 3 -> I_out=-200, Q_out=-100.
- Saturation: phase 2, lane 0 i=-32768, q=32767 -> I_out lane0=32767, Q_out lane0=-32767; other lanes are unaffected.
- Per-cycle phase switching: stream 200 words of a 10 MHz sine/cosine pair (I_in=cos, Q_in=sin, 16-bit full-scale) with phase cycling 0,1,3,2 on consecutive words -> each output word matches the mapping for the phase presented with that word, 1 cycle later.
- Lane independence: distinct values in each lane with phase 3 -> each output lane is derived only from its own input lane; lane order is preserved.
